// File: rtl/rgb_packer_if.sv
// Output word bus of rgb_packer: packed RGB head word plus eol/eof tags, valid/ready handshake.
// master = packer (drives the word), slave = frame sink (drives ready).
interface rgb_packer_if #(
  parameter int DATA_W = 8
);
  logic [3*DATA_W-1:0] out_rgb;
  logic                out_eol;
  logic                out_eof;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_rgb, out_eol, out_eof, out_valid, input  out_ready);
  modport slave  (input  out_rgb, out_eol, out_eof, out_valid, output out_ready);
endinterface

// File: rtl/rgb_packer.sv
// Packs serial R/G/B samples into {R,G,B} words and buffers them in a small FIFO for the frame sink.
// Optional per-frame pixel counter enabled by defining RGB_PACKER_PIXCNT_EN.
module rgb_packer #(
  parameter int DATA_W     = 8,
  parameter int COLOR_W    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  pixel_in,
  input  logic               valid_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               last_col_in,
  input  logic               last_pic_in,
  rgb_packer_if.master       ob,
  output logic               frame_done,
  output logic               seq_err,
  output logic               ovf_err,
  input  logic               clear_err,
  output logic [15:0]        frame_pix_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3*DATA_W + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [COLOR_W-1:0] C_R = COLOR_W'(0);
  localparam logic [COLOR_W-1:0] C_G = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] C_B = COLOR_W'(2);

  typedef enum logic [1:0] {EXP_R, EXP_G, EXP_B} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d, g_q, g_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d, ovf_err_q, ovf_err_d;
  logic              push_req, push, pop, drop, seq_viol, full;
  logic [EW-1:0]     head;

  // Packing FSM: a wrong tag discards the partial pixel, but an R tag restarts a new pixel.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    g_d      = g_q;
    seq_viol = 1'b0;
    push_req = 1'b0;
    if (valid_in) begin
      case (state_q)
        EXP_R: begin
          if (color_in == C_R) begin
            r_d     = pixel_in;
            state_d = EXP_G;
          end else begin
            seq_viol = 1'b1;
            state_d  = EXP_R;
          end
        end
        EXP_G: begin
          if (color_in == C_G) begin
            g_d     = pixel_in;
            state_d = EXP_B;
          end else if (color_in == C_R) begin
            seq_viol = 1'b1;
            r_d      = pixel_in;
            state_d  = EXP_G;
          end else begin
            seq_viol = 1'b1;
            state_d  = EXP_R;
          end
        end
        EXP_B: begin
          if (color_in == C_B) begin
            push_req = 1'b1;
            state_d  = EXP_R;
          end else if (color_in == C_R) begin
            seq_viol = 1'b1;
            r_d      = pixel_in;
            state_d  = EXP_G;
          end else begin
            seq_viol = 1'b1;
            state_d  = EXP_R;
          end
        end
        default: state_d = EXP_R;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign full = (cnt_q == FULL_CNT);
  assign pop  = (cnt_q != '0) && ob.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {r_q, g_q, pixel_in, last_col_in | last_pic_in, last_pic_in};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    frame_done_d = pop && head[0];
    seq_err_d    = (seq_err_q && !clear_err) || seq_viol;
    ovf_err_d    = (ovf_err_q && !clear_err) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EXP_R;
      r_q          <= '0;
      g_q          <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      g_q          <= g_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign ob.out_rgb   = head[EW-1:2];
  assign ob.out_eol   = head[1];
  assign ob.out_eof   = head[0];
  assign ob.out_valid = (cnt_q != '0);
  assign frame_done   = frame_done_q;
  assign seq_err      = seq_err_q;
  assign ovf_err      = ovf_err_q;

`ifdef RGB_PACKER_PIXCNT_EN
  logic [15:0] pix_cnt_q, pix_cnt_d, frame_pix_cnt_q, frame_pix_cnt_d, pix_inc;

  // Counts only words that actually enter the FIFO; saturates rather than wrapping.
  always_comb begin
    pix_inc         = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
    pix_cnt_d       = pix_cnt_q;
    frame_pix_cnt_d = frame_pix_cnt_q;
    if (push) begin
      if (last_pic_in) begin
        frame_pix_cnt_d = pix_inc;
        pix_cnt_d       = '0;
      end else begin
        pix_cnt_d = pix_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q       <= '0;
      frame_pix_cnt_q <= '0;
    end else begin
      pix_cnt_q       <= pix_cnt_d;
      frame_pix_cnt_q <= frame_pix_cnt_d;
    end
  end

  assign frame_pix_cnt = frame_pix_cnt_q;
`else
  assign frame_pix_cnt = '0;
`endif
endmodule

// File: tb/tb_rgb_packer.sv
// Directed bench for rgb_packer: packing, sequence errors, overflow, full push+pop, reset, error clear.
module tb_rgb_packer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [1:0] color_in;
  logic       last_col_in, last_pic_in;
  logic       frame_done, seq_err, ovf_err, clear_err;
  logic [15:0] frame_pix_cnt;
  int n_vec = 0;
  int n_err = 0;

`ifdef RGB_PACKER_PIXCNT_EN
  localparam logic [15:0] EXP_PIXCNT = 16'd4;
`else
  localparam logic [15:0] EXP_PIXCNT = 16'd0;
`endif

  rgb_packer_if #(.DATA_W(8)) bus ();

  rgb_packer #(.DATA_W(8), .COLOR_W(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_col_in(last_col_in), .last_pic_in(last_pic_in), .ob(bus),
    .frame_done(frame_done), .seq_err(seq_err), .ovf_err(ovf_err), .clear_err(clear_err),
    .frame_pix_cnt(frame_pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample: driven after a falling edge, captured on the next rising edge.
  task automatic smp(input logic [1:0] c, input logic [7:0] p, input logic lc = 1'b0, input logic lp = 1'b0);
    valid_in = 1'b1; color_in = c; pixel_in = p; last_col_in = lc; last_pic_in = lp;
    @(negedge clk);
    valid_in = 1'b0; last_col_in = 1'b0; last_pic_in = 1'b0;
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic lc = 1'b0, input logic lp = 1'b0);
    smp(2'd0, r); smp(2'd1, g); smp(2'd2, b, lc, lp);
  endtask

  initial begin
    logic [23:0] w;
    rst = 1'b1; valid_in = 1'b0; color_in = '0; pixel_in = '0;
    last_col_in = 1'b0; last_pic_in = 1'b0; clear_err = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_rgb", 32'(bus.out_rgb), 0);
    chk("rst_flags", {30'd0, seq_err, ovf_err}, 0);
    chk("rst_done_cnt", {15'd0, frame_done, frame_pix_cnt}, 0);

    // Four-pixel frame, sink always ready
    bus.out_ready = 1'b1;
    px(8'd10, 8'd20, 8'd30);
    chk("f_w1", {5'd0, bus.out_valid, bus.out_eol, bus.out_eof, bus.out_rgb}, {5'd0, 3'b100, 24'h0A141E});
    px(8'd20, 8'd30, 8'd40, 1'b1, 1'b0);
    chk("f_w2", {5'd0, bus.out_valid, bus.out_eol, bus.out_eof, bus.out_rgb}, {5'd0, 3'b110, 24'h141E28});
    px(8'd30, 8'd40, 8'd50);
    chk("f_w3", {5'd0, bus.out_valid, bus.out_eol, bus.out_eof, bus.out_rgb}, {5'd0, 3'b100, 24'h1E2832});
    px(8'd40, 8'd50, 8'd60, 1'b0, 1'b1);
    chk("f_w4", {5'd0, bus.out_valid, bus.out_eol, bus.out_eof, bus.out_rgb}, {5'd0, 3'b111, 24'h28323C});
    chk("f_done_early", 32'(frame_done), 0);
    @(negedge clk);
    chk("f_done_pulse", 32'(frame_done), 1);
    chk("f_drained", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("f_done_off", 32'(frame_done), 0);
    chk("f_pixcnt", 32'(frame_pix_cnt), 32'(EXP_PIXCNT));

    // R1 B2 R3 G4 B5: one violation, one word
    smp(2'd0, 8'd1); smp(2'd2, 8'd2);
    chk("s_err", 32'(seq_err), 1);
    chk("s_nopush", 32'(bus.out_valid), 0);
    smp(2'd0, 8'd3); smp(2'd1, 8'd4); smp(2'd2, 8'd5);
    chk("s_word", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, 24'h030405});
    @(negedge clk);
    chk("s_single", 32'(bus.out_valid), 0);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("s_clear", 32'(seq_err), 0);

    // Overflow: nine pixels, sink stalled
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) px(8'(k), 8'(k + 16), 8'(k + 32));
    chk("o_no_ovf8", 32'(ovf_err), 0);
    px(8'd9, 8'd25, 8'd41);
    chk("o_ovf", 32'(ovf_err), 1);
    chk("o_hold", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, 24'h011121});
    @(negedge clk);
    chk("o_hold2", 32'(bus.out_rgb), 32'h011121);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      w = {8'(k), 8'(k + 16), 8'(k + 32)};
      chk("o_drain", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, w});
      @(negedge clk);
    end
    chk("o_empty", 32'(bus.out_valid), 0);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("o_clear", {30'd0, seq_err, ovf_err}, 0);

    // Full FIFO with simultaneous push and pop
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) px(8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k));
    smp(2'd0, 8'h49); smp(2'd1, 8'h59);
    bus.out_ready = 1'b1;
    smp(2'd2, 8'h69);
    bus.out_ready = 1'b0;
    chk("p_no_ovf", 32'(ovf_err), 0);
    chk("p_head", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, 24'h425262});
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      w = {8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k)};
      chk("p_drain", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, w});
      @(negedge clk);
    end
    chk("p_empty", 32'(bus.out_valid), 0);

    // Reset mid-pixel
    smp(2'd1, 8'h11);
    chk("r_pre_err", 32'(seq_err), 1);
    smp(2'd0, 8'h77); smp(2'd1, 8'h88);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("r_flags", {30'd0, seq_err, ovf_err}, 0);
    chk("r_empty", 32'(bus.out_valid), 0);
    px(8'hAA, 8'hBB, 8'hCC);
    chk("r_word", {7'd0, bus.out_valid, bus.out_rgb}, {7'd0, 1'b1, 24'hAABBCC});
    @(negedge clk);
    chk("r_single", 32'(bus.out_valid), 0);

    // clear_err colliding with a new violation
    smp(2'd1, 8'h01);
    chk("c_err", 32'(seq_err), 1);
    clear_err = 1'b1;
    smp(2'd2, 8'h02);
    clear_err = 1'b0;
    chk("c_new_wins", 32'(seq_err), 1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("c_cleared", 32'(seq_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
